// File: rtl/sprite_mixer.sv
// Sprite/background compositor: samples sprite and background pixels once per
// 4-clock slot, resolves priority, and exposes colour/collision/vblank registers.
module sprite_mixer (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rw,
  input  logic [3:0] addr,
  input  logic [7:0] di,
  output logic [7:0] dout,
  input  logic [3:0] sprite_px,
  input  logic [1:0] bg_px,
  input  logic       hsync,
  input  logic       vsync,
  output logic [7:0] color,
  output logic       irq
);

  typedef enum logic [3:0] {
    A_PRIO  = 4'd8,
    A_SSCOL = 4'd9,
    A_SBCOL = 4'd10,
    A_CTRL  = 4'd11,
    A_STAT  = 4'd12
  } reg_addr_e;

  logic [7:0] r_sprcol [4];
  logic [7:0] r_bgcol  [4];
  logic [3:0] r_prio;
  logic [3:0] r_sscol;
  logic [3:0] r_sbcol;
  logic [1:0] r_ctrl;
  logic       r_stat;
  logic [1:0] r_phase;
  logic       r_vsync_d;
  logic [7:0] r_color;
  logic [7:0] r_dout;

  logic       w_sample;
  logic       w_wr;
  logic       w_rd;
  logic [7:0] w_rd_data;
  logic       w_any_sprite;
  logic [1:0] w_winner;
  logic [7:0] w_pixel;
  logic       w_multi;
  logic [3:0] w_ss_set;
  logic [3:0] w_sb_set;
  logic       w_vb_set;
  logic       w_clr_ss;
  logic       w_clr_sb;
  logic       w_clr_stat;

  assign w_sample = (r_phase == 2'd0);
  assign w_wr     = cs & rw;
  assign w_rd     = cs & ~rw;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_rd_data = 8'h00;
    if (addr[3:2] == 2'b00) begin
      w_rd_data = r_sprcol[addr[1:0]];
    end else if (addr[3:2] == 2'b01) begin
      w_rd_data = r_bgcol[addr[1:0]];
    end else begin
      case (addr)
        A_PRIO:  w_rd_data = {4'h0, r_prio};
        A_SSCOL: w_rd_data = {4'h0, r_sscol};
        A_SBCOL: w_rd_data = {4'h0, r_sbcol};
        A_CTRL:  w_rd_data = {6'h00, r_ctrl};
        A_STAT:  w_rd_data = {7'h00, r_stat};
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_any_sprite = |sprite_px;
    w_winner     = 2'd0;
    if (sprite_px[0])      w_winner = 2'd0;
    else if (sprite_px[1]) w_winner = 2'd1;
    else if (sprite_px[2]) w_winner = 2'd2;
    else if (sprite_px[3]) w_winner = 2'd3;
  end

  always_comb begin
    w_pixel = r_sprcol[w_winner];
    if (!w_any_sprite || (r_prio[w_winner] && bg_px != 2'd0)) begin
      w_pixel = r_bgcol[bg_px];
    end
    // Sync blanking wins over every priority decision.
    if (r_ctrl[1] && (hsync || vsync)) begin
      w_pixel = 8'h00;
    end
  end

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign w_multi    = ((sprite_px & (sprite_px - 4'd1)) != 4'd0);
  assign w_ss_set   = (w_sample && w_multi) ? sprite_px : 4'd0;
  assign w_sb_set   = (w_sample && bg_px != 2'd0) ? sprite_px : 4'd0;
  assign w_vb_set   = vsync & ~r_vsync_d & r_ctrl[0];
  assign w_clr_ss   = w_rd && (addr == A_SSCOL);
  assign w_clr_sb   = w_rd && (addr == A_SBCOL);
  assign w_clr_stat = w_rd && (addr == A_STAT);

  // NOTE: the colour tables are a handful of flops, so they take the reset
  // like any other state rather than being treated as an unreset RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        r_sprcol[k] <= 8'h00;
        r_bgcol[k]  <= 8'h00;
      end
      r_prio <= 4'h0;
      r_ctrl <= 2'b00;
      r_dout <= 8'h00;
    end else begin
      if (w_wr) begin
        if (addr[3:2] == 2'b00) begin
          r_sprcol[addr[1:0]] <= di;
        end else if (addr[3:2] == 2'b01) begin
          r_bgcol[addr[1:0]] <= di;
        end else if (addr == A_PRIO) begin
          r_prio <= di[3:0];
        end else if (addr == A_CTRL) begin
          r_ctrl <= di[1:0];
        end
      end
      if (w_rd) begin
        r_dout <= w_rd_data;
      end
    end
  end

  // Read-to-clear drops the old bits but keeps anything set on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sscol   <= 4'h0;
      r_sbcol   <= 4'h0;
      r_stat    <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_sscol   <= (w_clr_ss   ? 4'h0 : r_sscol) | w_ss_set;
      r_sbcol   <= (w_clr_sb   ? 4'h0 : r_sbcol) | w_sb_set;
      r_stat    <= (w_clr_stat ? 1'b0 : r_stat)  | w_vb_set;
      r_vsync_d <= vsync;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= 2'd0;
      r_color <= 8'h00;
    end else begin
      r_phase <= r_phase + 2'd1;
      if (w_sample) begin
        r_color <= w_pixel;
      end
    end
  end

  assign dout  = r_dout;
  assign color = r_color;
  assign irq   = r_stat;

endmodule

// File: tb/tb_sprite_mixer.sv
// Bench for sprite_mixer: directed test-plan steps followed by random traffic
// checked cycle by cycle against a slot-level reference model.
module tb_sprite_mixer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] addr = 4'h0;
  logic [7:0] di = 8'h00;
  logic [7:0] dout;
  logic [3:0] sprite_px = 4'h0;
  logic [1:0] bg_px = 2'd0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] color;
  logic       irq;

  int checks = 0;
  int failures = 0;

  sprite_mixer dut (
    .clk(clk), .reset(reset), .cs(cs), .rw(rw), .addr(addr), .di(di),
    .dout(dout), .sprite_px(sprite_px), .bg_px(bg_px), .hsync(hsync),
    .vsync(vsync), .color(color), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: slot number from a cycle count, registers as plain arrays.
  logic [7:0] m_sprcol [4];
  logic [7:0] m_bgcol  [4];
  logic [3:0] m_prio, m_ss, m_sb, m_ss_set, m_sb_set;
  logic [1:0] m_ctrl;
  logic       m_stat, m_vs_d;
  logic [7:0] m_color, m_dout, m_rd;
  int         m_cycle, m_win;
  bit         m_read;

  function automatic logic [7:0] m_reg(input logic [3:0] a);
    if (a < 4)   return m_sprcol[a[1:0]];
    if (a < 8)   return m_bgcol[a[1:0]];
    if (a == 8)  return {4'h0, m_prio};
    if (a == 9)  return {4'h0, m_ss};
    if (a == 10) return {4'h0, m_sb};
    if (a == 11) return {6'h00, m_ctrl};
    if (a == 12) return {7'h00, m_stat};
    return 8'h00;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        m_sprcol[k] = 8'h00;
        m_bgcol[k]  = 8'h00;
      end
      m_prio = 0; m_ss = 0; m_sb = 0; m_ctrl = 0; m_stat = 0; m_vs_d = 0;
      m_color = 0; m_dout = 0; m_cycle = 0;
    end else begin
      m_rd     = m_reg(addr);
      m_read   = cs && !rw;
      m_ss_set = 4'h0;
      m_sb_set = 4'h0;
      if (m_cycle % 4 == 0) begin
        m_win = -1;
        for (int k = 3; k >= 0; k--) if (sprite_px[k]) m_win = k;
        if (m_ctrl[1] && (hsync || vsync))                  m_color = 8'h00;
        else if (m_win < 0 || (m_prio[m_win] && bg_px != 0)) m_color = m_bgcol[bg_px];
        else                                                 m_color = m_sprcol[m_win];
        if ($countones(sprite_px) >= 2) m_ss_set = sprite_px;
        if (bg_px != 0)                 m_sb_set = sprite_px;
      end
      m_ss   = ((m_read && addr == 9)  ? 4'h0 : m_ss) | m_ss_set;
      m_sb   = ((m_read && addr == 10) ? 4'h0 : m_sb) | m_sb_set;
      m_stat = ((m_read && addr == 12) ? 1'b0 : m_stat) | (vsync && !m_vs_d && m_ctrl[0]);
      if (m_read) m_dout = m_rd;
      if (cs && rw) begin
        if (addr < 4)       m_sprcol[addr[1:0]] = di;
        else if (addr < 8)  m_bgcol[addr[1:0]]  = di;
        else if (addr == 8) m_prio = di[3:0];
        else if (addr == 11) m_ctrl = di[1:0];
      end
      m_vs_d  = vsync;
      m_cycle = m_cycle + 1;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b1; addr = a; di = d;
    step(1);
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    cs = 1'b1; rw = 1'b0; addr = a;
    step(1);
    cs = 1'b0;
    v = dout;
  endtask

  // Advance until the next clock edge is a sample edge.
  task automatic align;
    while (m_cycle % 4 != 0) step(1);
  endtask

  task automatic slot(input logic [3:0] sp, input logic [1:0] bg);
    sprite_px = sp; bg_px = bg;
    align();
    step(1);
  endtask

  logic [7:0] v;

  initial begin
    // Reset held across edges, then load state so outputs are non-zero.
    step(2);
    reset = 1'b0;
    wr(4'd0, 8'hAB);
    wr(4'd11, 8'h01);
    slot(4'b0001, 2'd0);
    check("pre_reset_color", color, 8'hAB);
    rd(4'd0, v);
    check("pre_reset_dout", v, 8'hAB);
    vsync = 1'b1;
    step(1);
    check("pre_reset_irq", {7'h0, irq}, 8'h01);
    vsync = 1'b0; sprite_px = 4'h0;
    while (m_cycle % 4 != 2) step(1);
    reset = 1'b1;
    #1;
    check("reset_color", color, 8'h00);
    check("reset_dout", dout, 8'h00);
    check("reset_irq", {7'h0, irq}, 8'h00);
    step(1);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), v);
      check($sformatf("reset_read_%0d", a), v, 8'h00);
    end

    // Priority.
    wr(4'd0, 8'h11); wr(4'd1, 8'h22); wr(4'd2, 8'h33); wr(4'd3, 8'h44);
    wr(4'd4, 8'h00); wr(4'd5, 8'h55); wr(4'd6, 8'h66); wr(4'd7, 8'h77);
    slot(4'b0110, 2'd0);
    check("prio_winner", color, 8'h22);
    wr(4'd8, 8'h02);
    slot(4'b0110, 2'd2);
    check("prio_behind_bg", color, 8'h66);
    slot(4'b0000, 2'd3);
    check("prio_bg_only", color, 8'h77);
    rd(4'd8, v);
    check("prio_readback", v, 8'h02);

    // Collisions.
    rd(4'd9, v);
    check("ss_from_prio", v, 8'h06);
    rd(4'd10, v);
    check("sb_from_prio", v, 8'h06);
    slot(4'b0101, 2'd0);
    sprite_px = 4'h0;
    rd(4'd9, v);
    check("ss_first_read", v, 8'h05);
    rd(4'd9, v);
    check("ss_second_read", v, 8'h00);
    slot(4'b1000, 2'd1);
    sprite_px = 4'h0; bg_px = 2'd0;
    rd(4'd10, v);
    check("sb_read", v, 8'h08);
    slot(4'b0101, 2'd0);
    sprite_px = 4'b0011;
    align();
    rd(4'd9, v);
    check("ss_same_edge_old", v, 8'h05);
    sprite_px = 4'h0;
    rd(4'd9, v);
    check("ss_same_edge_new", v, 8'h03);

    // Blanking during sync.
    wr(4'd11, 8'h02);
    hsync = 1'b1;
    slot(4'b0001, 2'd0);
    check("blank_color", color, 8'h00);
    slot(4'b0011, 2'd1);
    check("blank_color2", color, 8'h00);
    sprite_px = 4'h0; bg_px = 2'd0; hsync = 1'b0;
    rd(4'd9, v);
    check("blank_ss", v, 8'h03);
    rd(4'd10, v);
    check("blank_sb", v, 8'h03);

    // Vblank interrupt.
    wr(4'd11, 8'h01);
    vsync = 1'b1;
    #1;
    check("vb_irq_before", {7'h0, irq}, 8'h00);
    step(1);
    check("vb_irq_set", {7'h0, irq}, 8'h01);
    wr(4'd11, 8'h00);
    check("vb_irq_ctrl_off", {7'h0, irq}, 8'h01);
    rd(4'd12, v);
    check("vb_stat_read", v, 8'h01);
    check("vb_irq_cleared", {7'h0, irq}, 8'h00);
    vsync = 1'b0;
    step(2);
    vsync = 1'b1;
    step(2);
    check("vb_disabled", {7'h0, irq}, 8'h00);
    vsync = 1'b0;

    // Write on a sample edge lands in the following slot.
    slot(4'b0001, 2'd0);
    check("wt_before", color, 8'h11);
    align();
    wr(4'd0, 8'h99);
    check("wt_same_slot", color, 8'h11);
    step(3);
    check("wt_still_old", color, 8'h11);
    step(1);
    check("wt_next_slot", color, 8'h99);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cs        = ($urandom_range(2) == 0);
      rw        = $urandom_range(1);
      addr      = 4'($urandom_range(15));
      di        = 8'($urandom);
      sprite_px = 4'($urandom);
      bg_px     = 2'($urandom);
      hsync     = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) vsync = ~vsync;
      step(1);
      check("rand_color", color, m_color);
      check("rand_dout", dout, m_dout);
      check("rand_irq", {7'h0, irq}, {7'h0, m_stat});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
